cv32e40p_x_disp_mo: RTL and testbench



---
 rtl/cv32e40p_x_disp_mo.sv | 185 ++++++++++++++++++
 tb/tb_cv32e40p_x_disp_mo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_x_disp_mo.sv
// Multi-outstanding x-interface dispatcher: tags offloads with IDs and tracks in-flight rd via pending counters.
// Define CV32E40P_X_DISP_IN_ORDER_EN for an in-order (FIFO) result table; the default is an out-of-order CAM.
module cv32e40p_x_disp_mo #(
  parameter int NUM_OUTSTANDING = 4,
  parameter int ID_WIDTH        = 4,
  parameter int NUM_RS          = 3,
  localparam int CNT_W          = $clog2(NUM_OUTSTANDING + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  x_illegal_insn_dec_i,
  input  logic                  x_branch_or_jump_i,
  input  logic                  id_ready_i,
  input  logic                  x_writeback_i,
  input  logic [4:0]            x_waddr_id_i,
  input  logic [4:0]            x_waddr_ex_i,
  input  logic [4:0]            x_waddr_wb_i,
  input  logic                  x_we_ex_i,
  input  logic                  x_we_wb_i,
  input  logic [NUM_RS*5-1:0]   x_rs_addr_i,
  input  logic [NUM_RS-1:0]     x_regs_used_i,
  output logic                  x_valid_o,
  input  logic                  x_ready_i,
  input  logic                  x_accept_i,
  output logic [ID_WIDTH-1:0]   x_id_o,
  output logic [NUM_RS-1:0]     x_rs_valid_o,
  output logic                  x_rd_clean_o,
  output logic                  x_stall_o,
  output logic                  x_illegal_insn_o,
  input  logic                  x_rvalid_i,
  input  logic [ID_WIDTH-1:0]   x_rid_i,
  output logic                  x_rready_o,
  output logic [CNT_W-1:0]      x_outstanding_o,
  output logic                  x_full_o,
  output logic                  x_id_err_o
);

  localparam int PTR_W = (NUM_OUTSTANDING > 1) ? $clog2(NUM_OUTSTANDING) : 1;

  logic [NUM_OUTSTANDING-1:0] ent_valid;
  logic [NUM_OUTSTANDING-1:0] ent_we;
  logic [ID_WIDTH-1:0]        ent_id [NUM_OUTSTANDING];
  logic [4:0]                 ent_rd [NUM_OUTSTANDING];
  logic [CNT_W-1:0]           cnt [32];
  logic [ID_WIDTH-1:0]        next_id;
  logic                       offloaded_q;
  logic [CNT_W-1:0]           outstanding_q;
  logic                       full_q;
  logic                       cand;
  logic                       id_busy;
  logic                       accept;
  logic                       retire;
  logic                       dep;
  logic [PTR_W-1:0]           alloc_idx;
  logic [PTR_W-1:0]           free_idx;
  logic [31:0]                cnt_inc;
  logic [31:0]                cnt_dec;

  // Full comes from the registered count, so a retire while full only reopens issue next cycle.
  assign full_q = (outstanding_q == CNT_W'(NUM_OUTSTANDING));

  assign cand             = x_illegal_insn_dec_i & ~x_branch_or_jump_i & ~offloaded_q;
  assign x_valid_o        = cand & ~full_q & ~id_busy;
  assign accept           = x_valid_o & x_ready_i & x_accept_i;
  assign x_illegal_insn_o = x_valid_o & x_ready_i & ~x_accept_i;
  assign x_id_o           = next_id;
  assign x_rready_o       = 1'b1;
  assign x_outstanding_o  = outstanding_q;
  assign x_full_o         = full_q;
  assign x_id_err_o       = x_rvalid_i & ~retire;
  assign x_stall_o        = (x_valid_o & ~x_ready_i) | dep | (cand & (full_q | id_busy));

  always_comb begin
    id_busy = 1'b0;
    for (int i = 0; i < NUM_OUTSTANDING; i++) begin
      if (ent_valid[i] && (ent_id[i] == next_id)) id_busy = 1'b1;
    end
  end

`ifdef CV32E40P_X_DISP_IN_ORDER_EN
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign alloc_idx = tail_q;
  assign free_idx  = head_q;
  assign retire    = x_rvalid_i & ent_valid[head_q] & (ent_id[head_q] == x_rid_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (accept) tail_q <= ptr_inc(tail_q);
      if (retire) head_q <= ptr_inc(head_q);
    end
  end
`else
  // IDs are unique among valid entries (id_busy blocks reuse), so at most one entry matches.
  always_comb begin
    alloc_idx = '0;
    free_idx  = '0;
    retire    = 1'b0;
    for (int i = NUM_OUTSTANDING - 1; i >= 0; i--) begin
      if (!ent_valid[i]) alloc_idx = PTR_W'(i);
      if (ent_valid[i] && (ent_id[i] == x_rid_i)) begin
        free_idx = PTR_W'(i);
        retire   = x_rvalid_i;
      end
    end
  end
`endif

  always_comb begin
    x_rs_valid_o = '0;
    dep          = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      x_rs_valid_o[i] = ~((cnt[x_rs_addr_i[i*5 +: 5]] != '0) |
                          ((x_rs_addr_i[i*5 +: 5] == x_waddr_ex_i) & x_we_ex_i) |
                          ((x_rs_addr_i[i*5 +: 5] == x_waddr_wb_i) & x_we_wb_i));
      if (x_regs_used_i[i] && (cnt[x_rs_addr_i[i*5 +: 5]] != '0)) dep = 1'b1;
    end
  end

  assign x_rd_clean_o = ~((cnt[x_waddr_id_i] != '0) |
                          ((x_waddr_id_i == x_waddr_ex_i) & x_we_ex_i) |
                          ((x_waddr_id_i == x_waddr_wb_i) & x_we_wb_i));

  always_comb begin
    cnt_inc = '0;
    cnt_dec = '0;
    if (accept && x_writeback_i) cnt_inc[x_waddr_id_i] = 1'b1;
    if (retire && ent_we[free_idx]) cnt_dec[ent_rd[free_idx]] = 1'b1;
    cnt_inc[0] = 1'b0;
    cnt_dec[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < 32; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        if (cnt_inc[r] && !cnt_dec[r]) cnt[r] <= cnt[r] + CNT_W'(1);
        else if (cnt_dec[r] && !cnt_inc[r]) cnt[r] <= cnt[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent_valid <= '0;
      ent_we    <= '0;
      for (int i = 0; i < NUM_OUTSTANDING; i++) begin
        ent_id[i] <= '0;
        ent_rd[i] <= '0;
      end
    end else begin
      if (retire) ent_valid[free_idx] <= 1'b0;
      if (accept) begin
        ent_valid[alloc_idx] <= 1'b1;
        ent_we[alloc_idx]    <= x_writeback_i;
        ent_id[alloc_idx]    <= next_id;
        ent_rd[alloc_idx]    <= x_waddr_id_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      next_id       <= '0;
      offloaded_q   <= 1'b0;
      outstanding_q <= '0;
    end else begin
      if (accept) next_id <= next_id + ID_WIDTH'(1);
      if (id_ready_i) offloaded_q <= 1'b0;
      else if (accept) offloaded_q <= 1'b1;
      if (accept && !retire) outstanding_q <= outstanding_q + CNT_W'(1);
      else if (retire && !accept) outstanding_q <= outstanding_q - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cv32e40p_x_disp_mo.sv
// Self-checking bench for cv32e40p_x_disp_mo in its default out-of-order build (NUM_OUTSTANDING=4, ID_WIDTH=4).
module tb_cv32e40p_x_disp_mo;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        dec, branch, id_ready, wb;
  logic [4:0]  waddr_id, waddr_ex, waddr_wb;
  logic        we_ex, we_wb;
  logic [14:0] rs_addr;
  logic [2:0]  regs_used;
  logic        x_valid, x_ready, x_accept;
  logic [3:0]  x_id;
  logic [2:0]  rs_valid;
  logic        rd_clean, stall, illegal;
  logic        rvalid;
  logic [3:0]  rid;
  logic        rready;
  logic [2:0]  outstanding;
  logic        full, id_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       dec, wb, ready, accept, id_ready, rvalid, used;
    logic [4:0] rd, rs;
    logic [3:0] rid;
    logic       e_valid, e_rs_ok, e_stall, e_illegal, e_id_err, e_full;
    logic [3:0] e_id;
    logic [2:0] e_outst;
  } vec_t;

  vec_t vecs[$];

  cv32e40p_x_disp_mo #(.NUM_OUTSTANDING(4), .ID_WIDTH(4), .NUM_RS(3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .x_illegal_insn_dec_i(dec), .x_branch_or_jump_i(branch), .id_ready_i(id_ready),
    .x_writeback_i(wb), .x_waddr_id_i(waddr_id), .x_waddr_ex_i(waddr_ex), .x_waddr_wb_i(waddr_wb),
    .x_we_ex_i(we_ex), .x_we_wb_i(we_wb), .x_rs_addr_i(rs_addr), .x_regs_used_i(regs_used),
    .x_valid_o(x_valid), .x_ready_i(x_ready), .x_accept_i(x_accept), .x_id_o(x_id),
    .x_rs_valid_o(rs_valid), .x_rd_clean_o(rd_clean), .x_stall_o(stall),
    .x_illegal_insn_o(illegal), .x_rvalid_i(rvalid), .x_rid_i(rid), .x_rready_o(rready),
    .x_outstanding_o(outstanding), .x_full_o(full), .x_id_err_o(id_err)
  );

  always #5 clk_i = ~clk_i;

  function automatic vec_t mk(input logic d, input logic w, input logic [4:0] rd, input logic rdy,
                              input logic acc, input logic idr, input logic rv, input logic [3:0] ri,
                              input logic [4:0] rs, input logic u, input logic ev, input logic [3:0] eid,
                              input logic eok, input logic est, input logic eil, input logic eerr,
                              input logic [2:0] eo, input logic ef);
    vec_t v;
    v.dec = d; v.wb = w; v.rd = rd; v.ready = rdy; v.accept = acc; v.id_ready = idr;
    v.rvalid = rv; v.rid = ri; v.rs = rs; v.used = u;
    v.e_valid = ev; v.e_id = eid; v.e_rs_ok = eok; v.e_stall = est; v.e_illegal = eil;
    v.e_id_err = eerr; v.e_outst = eo; v.e_full = ef;
    return v;
  endfunction

  task automatic idle();
    dec = 0; branch = 0; id_ready = 0; wb = 0; waddr_id = 0; waddr_ex = 0; waddr_wb = 0;
    we_ex = 0; we_wb = 0; rs_addr = 0; regs_used = 0; x_ready = 0; x_accept = 0;
    rvalid = 0; rid = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    idle();
    dec = v.dec; wb = v.wb; waddr_id = v.rd; x_ready = v.ready; x_accept = v.accept;
    id_ready = v.id_ready; rvalid = v.rvalid; rid = v.rid;
    rs_addr = {10'd0, v.rs}; regs_used = {2'b00, v.used};
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge and sample 1 ns later.
  task automatic step_in();
    @(negedge clk_i);
  endtask

  initial begin
    idle();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    checkOutput("reset valid", x_valid, 0);
    checkOutput("reset illegal", illegal, 0);
    checkOutput("reset id_err", id_err, 0);
    checkOutput("reset outstanding", outstanding, 0);
    checkOutput("reset full", full, 0);
    checkOutput("reset rready", rready, 1);
    checkOutput("reset id", x_id, 0);

    //           dec wb rd rdy acc idr rv rid rs u | val id ok st il er os f
    vecs.push_back(mk(1,1,5, 1,1,1, 0,0, 5,0, 1,0, 1,0,0,0, 0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 5,1, 0,1, 0,1,0,0, 1,0));
    vecs.push_back(mk(1,1,7, 1,1,1, 0,0, 0,0, 1,1, 1,0,0,0, 1,0));
    vecs.push_back(mk(1,1,0, 1,1,1, 0,0, 0,0, 1,2, 1,0,0,0, 2,0));
    vecs.push_back(mk(1,0,9, 1,1,1, 0,0, 9,0, 1,3, 1,0,0,0, 3,0));
    vecs.push_back(mk(1,1,8, 1,1,1, 0,0, 7,0, 0,4, 0,1,0,0, 4,1));
    vecs.push_back(mk(1,1,8, 1,1,1, 1,2, 0,0, 0,4, 1,1,0,0, 4,1));
    vecs.push_back(mk(1,1,7, 1,1,1, 1,1, 7,0, 1,4, 0,0,0,0, 3,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 1,9, 7,0, 0,5, 0,0,0,1, 3,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 1,0, 5,1, 0,5, 0,1,0,0, 3,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 5,1, 0,5, 1,0,0,0, 2,0));
    vecs.push_back(mk(1,1,6, 1,0,0, 0,0, 0,0, 1,5, 1,0,1,0, 2,0));
    vecs.push_back(mk(1,1,6, 0,0,0, 0,0, 0,0, 1,5, 1,1,0,0, 2,0));
    vecs.push_back(mk(1,1,6, 1,1,0, 0,0, 0,0, 1,5, 1,0,0,0, 2,0));
    vecs.push_back(mk(1,1,6, 1,1,0, 0,0, 6,0, 0,6, 0,0,0,0, 3,0));
    vecs.push_back(mk(1,1,6, 0,0,1, 0,0, 0,0, 0,6, 1,0,0,0, 3,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 1,3, 9,1, 0,6, 1,0,0,0, 3,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 1,4, 7,1, 0,6, 0,1,0,0, 2,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 1,5, 7,1, 0,6, 1,0,0,0, 1,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 6,1, 0,6, 1,0,0,0, 0,0));

    foreach (vecs[i]) begin
      step_in();
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d valid", i), x_valid, vecs[i].e_valid);
      checkOutput($sformatf("v%0d id", i), x_id, vecs[i].e_id);
      checkOutput($sformatf("v%0d rs0_valid", i), rs_valid[0], vecs[i].e_rs_ok);
      checkOutput($sformatf("v%0d stall", i), stall, vecs[i].e_stall);
      checkOutput($sformatf("v%0d illegal", i), illegal, vecs[i].e_illegal);
      checkOutput($sformatf("v%0d id_err", i), id_err, vecs[i].e_id_err);
      checkOutput($sformatf("v%0d outstanding", i), outstanding, vecs[i].e_outst);
      checkOutput($sformatf("v%0d full", i), full, vecs[i].e_full);
    end

    // ID wrap: keep id 6 in flight, cycle 15 more IDs, then next_id collides with it.
    step_in(); idle();
    dec = 1; x_ready = 1; x_accept = 1; id_ready = 1;
    #1 checkOutput("wrap first id", x_id, 6);
    for (int k = 0; k < 15; k++) begin
      step_in(); idle();
      dec = 1; x_ready = 1; x_accept = 1; id_ready = 1;
      #1 checkOutput($sformatf("wrap id k%0d", k), x_id, (7 + k) % 16);
      step_in(); idle();
      rvalid = 1; rid = 4'((7 + k) % 16);
      #1 checkOutput($sformatf("wrap ret k%0d", k), id_err, 0);
    end
    step_in(); idle();
    dec = 1; x_ready = 1;
    #1;
    checkOutput("busy valid", x_valid, 0);
    checkOutput("busy stall", stall, 1);
    checkOutput("busy id", x_id, 6);
    step_in(); idle();
    rvalid = 1; rid = 6;
    #1 checkOutput("busy retire err", id_err, 0);
    step_in(); idle();
    dec = 1; x_ready = 1;
    #1;
    checkOutput("unbusy valid", x_valid, 1);
    checkOutput("unbusy illegal", illegal, 1);
    checkOutput("unbusy outstanding", outstanding, 0);

    // Branch blocks offload without stalling.
    step_in(); idle();
    dec = 1; branch = 1; x_ready = 1; x_accept = 1;
    #1;
    checkOutput("branch valid", x_valid, 0);
    checkOutput("branch stall", stall, 0);

    // EX/WB writes make sources and rd unclean.
    step_in(); idle();
    rs_addr = {5'd3, 5'd4, 5'd10}; regs_used = 3'b111;
    we_ex = 1; waddr_ex = 4; we_wb = 1; waddr_wb = 3; waddr_id = 4;
    #1;
    checkOutput("fwd rs_valid", rs_valid, 3'b001);
    checkOutput("fwd rd_clean hit", rd_clean, 0);
    checkOutput("fwd stall", stall, 0);
    waddr_id = 11;
    #1 checkOutput("fwd rd_clean miss", rd_clean, 1);

    // Reset mid-operation discards the in-flight entry; its late result is unmatched.
    step_in(); idle();
    dec = 1; wb = 1; waddr_id = 12; x_ready = 1; x_accept = 1; id_ready = 1;
    #1 checkOutput("rst accept id", x_id, 6);
    step_in(); idle();
    rs_addr = {10'd0, 5'd12}; waddr_id = 12;
    #1;
    checkOutput("rst pre rs_valid", rs_valid[0], 0);
    checkOutput("rst pre rd_clean", rd_clean, 0);
    checkOutput("rst pre outstanding", outstanding, 1);
    rst_ni = 0;
    #1;
    checkOutput("rst outstanding", outstanding, 0);
    checkOutput("rst rs_valid", rs_valid[0], 1);
    checkOutput("rst id", x_id, 0);
    step_in();
    rst_ni = 1;
    rvalid = 1; rid = 6;
    #1 checkOutput("rst late result err", id_err, 1);
    step_in(); idle();
    #1 checkOutput("rst err pulse ends", id_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
